// File: rtl/mc_defs.sv
// ---------------------------------------------------------------------------
// mc_defs
// Shared definitions for the multi-cycle MIPS controller and the ALU decoder:
// opcode/funct constants, ALU operation codes, FSM state encodings, mux select
// constants and the bundled control-word struct driven by mc_control.
// ---------------------------------------------------------------------------
package mc_defs;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   // ALU operation codes, matched by the ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Mux selects
   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] SRC_A_PC      = 2'b00;
   localparam logic [1:0] SRC_A_REG     = 2'b01;
   localparam logic [1:0] SRC_A_SHAMT   = 2'b10;
   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_EXE_BR = 4'd3,
      S_EXE_LS = 4'd4,
      S_MEM    = 4'd5,
      S_WB_AL  = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       ext_sel;
      logic [2:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/alu_dec.sv
// ---------------------------------------------------------------------------
// alu_dec
// Combinational opcode/funct -> ALU operation decoder, shared with the
// single-cycle controller.
//   op_i      in  6  instruction opcode
//   funct_i   in  6  instruction funct field
//   alu_op_o  out 3  ALU operation select
//   known_o   out 1  opcode (and funct, for R-type) is a supported instruction
// ---------------------------------------------------------------------------
module alu_dec
   import mc_defs::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] alu_op_o,
   output logic       known_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      known_o  = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            known_o = 1'b1;
            case (funct_i)
               FN_ADD:  alu_op_o = ALU_ADD;
               FN_SUB:  alu_op_o = ALU_SUB;
               FN_AND:  alu_op_o = ALU_AND;
               FN_OR:   alu_op_o = ALU_OR;
               FN_SLT:  alu_op_o = ALU_SLT;
               FN_SLL:  alu_op_o = ALU_SLL;
               default: known_o  = 1'b0;
            endcase
         end
         OP_ADDI, OP_LW, OP_SW: begin
            known_o  = 1'b1;
            alu_op_o = ALU_ADD;
         end
         OP_ORI: begin
            known_o  = 1'b1;
            alu_op_o = ALU_OR;
         end
         OP_BEQ: begin
            known_o  = 1'b1;
            alu_op_o = ALU_SUB;
         end
         // j and halt never use the ALU result but are valid instructions
         OP_J, OP_HALT: known_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
// Multi-cycle MIPS control unit. Steps each instruction through IF, ID,
// EXE_*, MEM and WB_* states and drives datapath enables and mux selects.
//   clk, rst            clock, asynchronous active-high reset
//   op, funct, zero     IR opcode/funct and ALU zero flag
//   pc_write, pc_src    PC load enable and source select
//   iord, mem_read/write memory address select and strobes
//   ir_write, reg_write IR and register-file write enables
//   reg_dst, mem_to_reg register-file destination and data selects
//   alu_src_a/b, ext_sel, alu_op  ALU operand/extension/operation selects
//   state               current FSM state (debug)
// ---------------------------------------------------------------------------
module mc_control
   import mc_defs::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic               ext_sel,
   output logic [2:0]         alu_op,
   output logic [STATE_W-1:0] state
);

   state_t     state_q, state_d;
   ctrl_t      ctrl;
   logic [2:0] dec_alu_op;
   logic       dec_known;
   logic       is_rtype, is_sll;

   alu_dec u_alu_dec (
      .op_i     (op),
      .funct_i  (funct),
      .alu_op_o (dec_alu_op),
      .known_o  (dec_known)
   );

   assign is_rtype = (op == OP_RTYPE);
   assign is_sll   = is_rtype && (funct == FN_SLL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            if (!dec_known) begin
               state_d = S_IF;           // unsupported opcode/funct: nop
            end else begin
               case (op)
                  OP_RTYPE, OP_ADDI, OP_ORI: state_d = S_EXE_AL;
                  OP_BEQ:                    state_d = S_EXE_BR;
                  OP_LW, OP_SW:              state_d = S_EXE_LS;
                  OP_HALT:                   state_d = S_HALT;
                  default:                   state_d = S_IF;   // j
               endcase
            end
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
         S_WB_AL:  state_d = S_IF;
         S_WB_LD:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_IF: begin
            ctrl.mem_read  = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_SRC_ALU;
            ctrl.pc_write  = 1'b1;
         end
         S_ID: begin
            // Branch target is computed speculatively into ALUOut
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_IMM_SH2;
            ctrl.ext_sel   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
            if (op == OP_J) begin
               ctrl.pc_src   = PC_SRC_JUMP;
               ctrl.pc_write = 1'b1;
            end
         end
         S_EXE_AL: begin
            ctrl.alu_src_a = is_sll ? SRC_A_SHAMT : SRC_A_REG;
            ctrl.alu_src_b = is_rtype ? SRC_B_REG : SRC_B_IMM;
            ctrl.ext_sel   = (op == OP_ADDI);
            ctrl.alu_op    = dec_alu_op;
         end
         S_EXE_BR: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_REG;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_SRC_ALUOUT;
            ctrl.pc_write  = zero;      // Mealy term: taken only on equality
         end
         S_EXE_LS: begin
            ctrl.alu_src_a = SRC_A_REG;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.ext_sel   = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEM: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_read  = (op == OP_LW);
            ctrl.mem_write = (op == OP_SW);
         end
         S_WB_AL: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = is_rtype;
         end
         S_WB_LD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         default: ;
      endcase
      // Reset silences every output at once, so nothing writes mid-abandon
      if (rst) ctrl = '0;
   end

   assign pc_write   = ctrl.pc_write;
   assign pc_src     = ctrl.pc_src;
   assign iord       = ctrl.iord;
   assign mem_read   = ctrl.mem_read;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign reg_write  = ctrl.reg_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign ext_sel    = ctrl.ext_sel;
   assign alu_op     = ctrl.alu_op;
   assign state      = STATE_W'(state_q);

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the MIPS CPU. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the ALU operation select `alu_op[2:0]` and the operand muxes feeding the ALU, and consumes the ALU `zero` flag to resolve `beq`. It replaces the single-cycle combinational controller when the datapath moves to shared memory with IR, A, B, ALUOut and MDR latches.

## Interface
Parameters:
- `STATE_W`, 4, width of state encoding and of `state` debug output

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `op`  in  6  IR[31:26], held stable by the IR latch from ID onward
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag
- `pc_write`  out  1  PC load enable
- `pc_src`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `iord`  out  1  memory address: 0 PC, 1 ALUOut
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  IR load enable
- `reg_write`  out  1  register-file write enable
- `reg_dst`  out  1  write register: 0 rt, 1 rd
- `mem_to_reg`  out  1  write data: 0 ALUOut, 1 MDR
- `alu_src_a`  out  2  00 PC, 01 A, 10 zero-extended shamt
- `alu_src_b`  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ext_sel`  out  1  1 sign-extend, 0 zero-extend
- `alu_op`  out  3  000 ADD, 001 SUB, 010 SLL, 011 OR, 100 AND, 101 SLT
- `state`  out  STATE_W  current state, debug only

## Operation
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000
  - I-type: addi 001000, ori 001101, lw 100011, sw 101011, beq 000100
  - j 000010
  - halt 111111
- States: IF, ID, EXE_AL, EXE_BR, EXE_LS, MEM, WB_AL, WB_LD, HALT.
- Every output not listed for a state is 0.
- IF: mem_read=1, ir_write=1, alu_src_a=00, alu_src_b=01, alu_op=ADD, pc_src=00, pc_write=1. Next state: ID.
- ID: alu_src_a=00, alu_src_b=11, ext_sel=1, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - R-type, addi, ori → EXE_AL
  - beq → EXE_BR
  - lw, sw → EXE_LS
  - halt → HALT
  - j: pc_src=10, pc_write=1 in ID itself, then → IF
  - unknown opcode or unknown funct: no writes, → IF (nop)
- EXE_AL: alu_src_a=01 (10 for sll), alu_src_b=00 for R-type, 10 for I-type. ext_sel=1 for addi, 0 for ori. alu_op from funct/opcode; ori→OR, addi→ADD. Next state: WB_AL.
- EXE_BR: alu_src_a=01, alu_src_b=00, alu_op=SUB, pc_src=01, pc_write=`zero` (combinational from the input). Next state: IF.
- EXE_LS: alu_src_a=01, alu_src_b=10, ext_sel=1, alu_op=ADD. Next state: MEM.
- MEM: iord=1.
  - lw: mem_read=1, → WB_LD
  - sw: mem_write=1, → IF
- WB_AL: reg_write=1, reg_dst=1 for R-type, 0 for I-type, mem_to_reg=0. Next state: IF.
- WB_LD: reg_write=1, reg_dst=0, mem_to_reg=1. Next state: IF.
- HALT: all enables 0; held until reset.

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from state plus `op`/`funct` (Moore, except the `pc_write`/`zero` term in EXE_BR).
- Cycles per instruction: j 2, beq 3, R-type/addi/ori 4, sw 4, lw 5, nop 2.
- Reset: `rst` high forces state=IF immediately, independent of `clk`. While `rst` is high, every output is 0 (pc_write, ir_write, mem_read, mem_write, reg_write and all mux selects), and `state`=IF encoding (0).
- First IF outputs appear after `rst` deasserts. The first fetch completes on the first rising edge after deassertion.
- Reset mid-instruction: the instruction is abandoned. No partial write occurs after `rst` rises.
- `op`/`funct` are sampled only in ID and later states. Their values during IF are don't-care.

## Structure
- Shared package `mc_defs` holds:
  - opcode and funct constants
  - ALU op codes, which the ALU compares against
  - state encodings: IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8
  - mux select constants
- One natural sub-module: `alu_dec`, combinational funct/opcode → alu_op, shared with the single-cycle controller.

## Test plan
- Reset then release, `op`=add funct → state sequence IF,ID,EXE_AL,WB_AL,IF. reg_write=1 and reg_dst=1 only in WB_AL. alu_op=000 in EXE_AL.
- lw (100011) → 5 cycles. iord=1 with mem_read=1 in MEM. mem_to_reg=1 and reg_write=1 in WB_LD.
- beq with `zero`=1 → pc_write=1, pc_src=01 in EXE_BR. Repeat with `zero`=0 → pc_write=0. Both return to IF after 3 cycles.
- sll (funct 000000) → alu_src_a=10, alu_op=010. ori → ext_sel=0, alu_src_b=10, alu_op=011.
- j → pc_write=1, pc_src=10 in ID, back in IF next cycle. Opcode 111110 → nop, no write enables.
- halt → state stays HALT for 20 cycles with all enables 0. `rst` asserted mid-MEM of sw → mem_write drops to 0 immediately and state=IF.
